// File: rtl/knight_pkg.sv
// Shared types and constants for the knight's-tour command path.
// State enum, cmd_proc opcodes, headings, BLE response bytes, cmd packer.
package knight_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } tour_state_t;

  localparam logic [3:0] OP_MOVE     = 4'h4;
  localparam logic [3:0] OP_MOVE_FAN = 4'h5;
  localparam logic [3:0] OP_CAL      = 4'h2;
  localparam logic [3:0] OP_TOUR     = 4'h6;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

  function automatic logic [15:0] mk_cmd(
    input logic [3:0] op,
    input logic [7:0] hdg,
    input logic [2:0] sq
  );
    return {op, hdg, 1'b0, sq};
  endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Command handshake bundle between UART wrapper, scheduler and cmd_proc.
// master: scheduler side (drives cmd/cmd_rdy/clr_cmd_rdy_UART/resp).
interface tour_cmd_if;

  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART,
    input  clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART,
    output cmd, cmd_rdy, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART,
    output clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART,
    input  cmd, cmd_rdy, resp
  );

endinterface

// File: rtl/knight_move_decode.sv
// One-hot knight move -> vertical leg and horizontal (fanfare) leg cmds.
// Ports: move_i[7:0] in; vert_cmd_o[15:0], horz_cmd_o[15:0] out.
import knight_pkg::*;

module knight_move_decode (
  input  logic [7:0]  move_i,
  output logic [15:0] vert_cmd_o,
  output logic [15:0] horz_cmd_o
);

  logic       one_hot;
  logic [7:0] v_hdg;
  logic [7:0] h_hdg;
  logic [2:0] v_sq;
  logic [2:0] h_sq;

  assign one_hot = (move_i != '0) &&
                   ((move_i & (move_i - 8'd1)) == '0);

  // Anything not one-hot falls back to the b0 move.
  always_comb begin
    v_hdg = HDG_N;
    v_sq  = 3'd2;
    h_hdg = HDG_E;
    h_sq  = 3'd1;
    if (one_hot) begin
      unique case (1'b1)
        move_i[0]: begin
          v_hdg = HDG_N; v_sq = 3'd2;
          h_hdg = HDG_E; h_sq = 3'd1;
        end
        move_i[1]: begin
          v_hdg = HDG_N; v_sq = 3'd2;
          h_hdg = HDG_W; h_sq = 3'd1;
        end
        move_i[2]: begin
          v_hdg = HDG_N; v_sq = 3'd1;
          h_hdg = HDG_W; h_sq = 3'd2;
        end
        move_i[3]: begin
          v_hdg = HDG_S; v_sq = 3'd1;
          h_hdg = HDG_W; h_sq = 3'd2;
        end
        move_i[4]: begin
          v_hdg = HDG_S; v_sq = 3'd2;
          h_hdg = HDG_W; h_sq = 3'd1;
        end
        move_i[5]: begin
          v_hdg = HDG_S; v_sq = 3'd2;
          h_hdg = HDG_E; h_sq = 3'd1;
        end
        move_i[6]: begin
          v_hdg = HDG_S; v_sq = 3'd1;
          h_hdg = HDG_E; h_sq = 3'd2;
        end
        move_i[7]: begin
          v_hdg = HDG_N; v_sq = 3'd1;
          h_hdg = HDG_E; h_sq = 3'd2;
        end
      endcase
    end
  end

  assign vert_cmd_o = mk_cmd(OP_MOVE, v_hdg, v_sq);
  assign horz_cmd_o = mk_cmd(OP_MOVE_FAN, h_hdg, h_sq);

endmodule

// File: rtl/tour_cmd.sv
// Command scheduler: UART pass-through in IDLE, tour move expansion else.
// Ports: clk, rst_n, start_tour, move, mv_indx, bus (tour_cmd_if.master).
import knight_pkg::*;

module tour_cmd #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  tour_cmd_if.master       bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MOVES - 1);

  tour_state_t      state_q;
  logic [IDX_W-1:0] idx_q;
  logic             rdy_q;
  logic             last;
  logic [15:0]      vert_cmd;
  logic [15:0]      horz_cmd;

  knight_move_decode u_dec (
    .move_i     (move),
    .vert_cmd_o (vert_cmd),
    .horz_cmd_o (horz_cmd)
  );

  assign last    = (idx_q == LAST);
  assign mv_indx = idx_q;

  // rdy_q only rises after a full cycle in VERT/HORZ and drops
  // on the consuming edge so cmd_proc never sees it twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rdy_q <= 1'b0;
          if (start_tour) begin
            idx_q   <= '0;
            state_q <= VERT;
          end
        end
        VERT: begin
          rdy_q <= !bus.clr_cmd_rdy;
          if (bus.clr_cmd_rdy) state_q <= WAIT_V;
        end
        WAIT_V: begin
          rdy_q <= 1'b0;
          if (bus.send_resp) state_q <= HORZ;
        end
        HORZ: begin
          rdy_q <= !bus.clr_cmd_rdy;
          if (bus.clr_cmd_rdy) state_q <= WAIT_H;
        end
        WAIT_H: begin
          rdy_q <= 1'b0;
          if (bus.send_resp) begin
            if (last) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= VERT;
            end
          end
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.cmd              = bus.cmd_UART;
    bus.cmd_rdy          = bus.cmd_rdy_UART;
    bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
    bus.resp             = RESP_ACK;
    unique case (state_q)
      VERT, WAIT_V: begin
        bus.cmd              = vert_cmd;
        bus.cmd_rdy          = rdy_q;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = RESP_POS;
      end
      HORZ, WAIT_H: begin
        bus.cmd              = horz_cmd;
        bus.cmd_rdy          = rdy_q;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = last ? RESP_ACK : RESP_POS;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd with a cmd_proc model.
// Reference model works from knight displacements, not the RTL tables.
module tb_tour_cmd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_tour = 1'b0;
  logic [7:0] move;
  logic [4:0] mv_indx;
  logic [7:0] mem [32];

  int n_tests = 0;
  int n_fail  = 0;
  int n_cmds  = 0;

  logic [15:0] dv [3];
  logic [15:0] dh [3];

  localparam int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  localparam int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  tour_cmd_if bus ();

  tour_cmd #(
    .NUM_MOVES (24),
    .IDX_W     (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_tour (start_tour),
    .move       (move),
    .mv_indx    (mv_indx),
    .bus        (bus)
  );

  assign move = mem[mv_indx];

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] model_cmd(input logic [7:0] m,
                                            input bit horz);
    int k;
    int d;
    logic [7:0] hdg;
    logic [3:0] op;
    logic [2:0] sq;
    k = 0;
    if ($countones(m) == 1)
      for (int i = 0; i < 8; i++)
        if (m[i]) k = i;
    if (horz) begin
      d   = DX[k];
      op  = 4'h5;
      hdg = (d > 0) ? 8'hBF : 8'h3F;
    end else begin
      d   = DY[k];
      op  = 4'h4;
      hdg = (d > 0) ? 8'h00 : 8'h7F;
    end
    sq = 3'((d < 0) ? -d : d);
    return {op, hdg, 1'b0, sq};
  endfunction

  task automatic serve(input logic [15:0] exp,
                       input logic [7:0] er,
                       input bit do_send,
                       output logic [15:0] obs);
    int w;
    w = 0;
    obs = '0;
    while (!bus.cmd_rdy && w < 20) begin
      tick();
      w++;
    end
    if (!bus.cmd_rdy) begin
      chk("rdy_wait", {31'b0, bus.cmd_rdy}, 1);
      return;
    end
    n_cmds++;
    obs = bus.cmd;
    chk("cmd", bus.cmd, exp);
    chk("resp_cmd", bus.resp, er);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("uart_clr_tour", {31'b0, bus.clr_cmd_rdy_UART}, 0);
    tick();
    bus.clr_cmd_rdy = 1'b0;
    chk("rdy_drop", {31'b0, bus.cmd_rdy}, 0);
    chk("cmd_hold", bus.cmd, exp);
    if (!do_send) return;
    repeat ($urandom_range(0, 2)) tick();
    bus.send_resp = 1'b1;
    #1;
    chk("resp_send", bus.resp, er);
    tick();
    bus.send_resp = 1'b0;
  endtask

  task automatic run_tour(input int abort_at,
                          input bit directed,
                          input int uart_at);
    logic [15:0] o;
    n_cmds = 0;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    chk("rdy_entry", {31'b0, bus.cmd_rdy}, 0);
    for (int k = 0; k < 24; k++) begin
      chk("mv_indx", mv_indx, k);
      if (k == uart_at) begin
        bus.cmd_UART     = 16'h2ABC;
        bus.cmd_rdy_UART = 1'b1;
      end
      serve(model_cmd(mem[k], 1'b0), 8'h5A, 1'b1, o);
      if (directed && k < 3) chk("dir_v", o, dv[k]);
      if (k == abort_at) begin
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        chk("ign_start", mv_indx, k);
        serve(model_cmd(mem[k], 1'b1), 8'h5A, 1'b0, o);
        return;
      end
      serve(model_cmd(mem[k], 1'b1),
            (k == 23) ? 8'hA5 : 8'h5A, 1'b1, o);
      if (directed && k < 3) chk("dir_h", o, dh[k]);
    end
    chk("cmd_count", n_cmds, 48);
    chk("end_idx", mv_indx, 0);
    chk("end_resp", bus.resp, 8'hA5);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    dv[0] = 16'h4002; dv[1] = 16'h47F1; dv[2] = 16'h47F1;
    dh[0] = 16'h5BF1; dh[1] = 16'h53F2; dh[2] = 16'h5BF2;
    bus.cmd_UART     = 16'h1234;
    bus.cmd_rdy_UART = 1'b1;
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h01;

    tick();
    tick();
    chk("rst_idx", mv_indx, 0);
    chk("rst_cmd", bus.cmd, 16'h1234);
    chk("rst_rdy", {31'b0, bus.cmd_rdy}, 1);
    chk("rst_resp", bus.resp, 8'hA5);
    rst_n = 1'b1;
    tick();

    bus.cmd_UART     = 16'h2000;
    bus.cmd_rdy_UART = 1'b1;
    bus.clr_cmd_rdy  = 1'b1;
    #1;
    chk("pt_cmd", bus.cmd, 16'h2000);
    chk("pt_rdy", {31'b0, bus.cmd_rdy}, 1);
    chk("pt_clr", {31'b0, bus.clr_cmd_rdy_UART}, 1);
    chk("pt_resp", bus.resp, 8'hA5);
    tick();
    bus.clr_cmd_rdy  = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    #1;
    chk("pt_rdy_off", {31'b0, bus.cmd_rdy}, 0);
    tick();

    for (int i = 0; i < 24; i++)
      mem[i] = 8'h01 << $urandom_range(0, 7);
    mem[0] = 8'h01;
    mem[1] = 8'h08;
    mem[2] = 8'h40;
    run_tour(-1, 1'b1, -1);
    chk("idle_rdy", {31'b0, bus.cmd_rdy}, 0);

    for (int i = 0; i < 24; i++)
      if ($urandom_range(0, 5) == 0)
        mem[i] = 8'($urandom_range(0, 255));
      else
        mem[i] = 8'h01 << $urandom_range(0, 7);
    mem[7] = 8'h00;
    mem[8] = 8'h81;
    run_tour(-1, 1'b0, 5);
    chk("arb_cmd", bus.cmd, 16'h2ABC);
    chk("arb_rdy", {31'b0, bus.cmd_rdy}, 1);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("arb_clr", {31'b0, bus.clr_cmd_rdy_UART}, 1);
    tick();
    bus.clr_cmd_rdy  = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    tick();

    for (int i = 0; i < 24; i++)
      mem[i] = 8'h01 << $urandom_range(0, 7);
    run_tour(10, 1'b0, -1);
    bus.cmd_UART     = 16'h1357;
    bus.cmd_rdy_UART = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort_idx", mv_indx, 0);
    chk("abort_cmd", bus.cmd, 16'h1357);
    chk("abort_rdy", {31'b0, bus.cmd_rdy}, 1);
    tick();
    chk("abort_resp", bus.resp, 8'hA5);
    rst_n = 1'b1;
    bus.cmd_rdy_UART = 1'b0;
    tick();
    chk("post_rdy", {31'b0, bus.cmd_rdy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
